// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns the EX/MEM load/store request into a
// held data-cache request, stalls the pipeline until dhit, and latches HALT.
module mem_access_unit #(
    parameter int WAIT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_EX_MEM,
    input  logic              dREN_EX_MEM,
    input  logic              dWEN_EX_MEM,
    input  logic              halt_EX_MEM,
    input  logic [31:0]       dmemaddr_EX_MEM,
    input  logic [31:0]       dmemstore_EX_MEM,
    input  logic              dhit,
    input  logic [31:0]       dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [31:0]       dmemaddr,
    output logic [31:0]       dmemstore,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              halt,
    output logic [WAIT_W-1:0] wait_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        DONE   = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic                access_s;
    logic                stall_s;
    logic                dmem_ren_r;
    logic                dmem_wen_r;
    logic [31:0]         dmem_addr_r;
    logic [31:0]         dmem_store_r;
    logic [31:0]         load_data_r;
    logic                load_valid_r;
    logic                halt_r;
    logic [WAIT_W-1:0]   wait_cycles_r;

    // Access decode and the stall, which must react in the same cycle the instruction arrives
    always_comb begin
        access_s = valid_EX_MEM & (dREN_EX_MEM | dWEN_EX_MEM);
        stall_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s || (valid_EX_MEM && halt_EX_MEM)) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            REQ:     stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            HALTED:  stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
    end

    // Control FSM with registered cache request, load capture and halt latch
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            dmem_ren_r    <= 1'b0;
            dmem_wen_r    <= 1'b0;
            dmem_addr_r   <= 32'h0000_0000;
            dmem_store_r  <= 32'h0000_0000;
            load_data_r   <= 32'h0000_0000;
            load_valid_r  <= 1'b0;
            halt_r        <= 1'b0;
            wait_cycles_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    load_valid_r <= 1'b0;
                    if (valid_EX_MEM && halt_EX_MEM) begin
                        state_r <= HALTED;
                        halt_r  <= 1'b1;
                    end else if (access_s) begin
                        // A simultaneous read+write request is treated as a store
                        state_r      <= REQ;
                        dmem_addr_r  <= dmemaddr_EX_MEM;
                        dmem_store_r <= dmemstore_EX_MEM;
                        dmem_wen_r   <= dWEN_EX_MEM;
                        dmem_ren_r   <= ~dWEN_EX_MEM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dhit) begin
                        state_r    <= DONE;
                        dmem_ren_r <= 1'b0;
                        dmem_wen_r <= 1'b0;
                        if (!dmem_wen_r) begin
                            load_data_r  <= dmemload;
                            load_valid_r <= 1'b1;
                        end else begin
                            load_valid_r <= 1'b0;
                        end
                    end else if (wait_cycles_r != WAIT_MAX) begin
                        wait_cycles_r <= wait_cycles_r + WAIT_ONE;
                    end else begin
                        wait_cycles_r <= WAIT_MAX;
                    end
                end
                DONE: begin
                    // EX/MEM advances at the end of DONE, so never re-arm from here
                    state_r      <= IDLE;
                    load_valid_r <= 1'b0;
                end
                HALTED: begin
                    state_r <= HALTED;
                    halt_r  <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    dmem_ren_r <= 1'b0;
                    dmem_wen_r <= 1'b0;
                end
            endcase
        end
    end

    assign dmemREN     = dmem_ren_r;
    assign dmemWEN     = dmem_wen_r;
    assign dmemaddr    = dmem_addr_r;
    assign dmemstore   = dmem_store_r;
    assign mem_stall   = stall_s;
    assign load_data   = load_data_r;
    assign load_valid  = load_valid_r;
    assign halt        = halt_r;
    assign wait_cycles = wait_cycles_r;

endmodule
